// File: rtl/Global.sv
// Shared widths and FSM state encoding for the division sequencer slice.
package Global;

  localparam int unsigned DW   = 4;
  localparam int unsigned DW_2 = 2 * DW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    DONE,
    ZERO
  } div_seq_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the shift-subtract sequence; flags the final step.
module div_iter_counter
  import Global::*;
#(
  parameter int unsigned N = DW,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == W'(N - 1));

endmodule

// File: rtl/division_sequencer.sv
// Control FSM for the shift-subtract divider: operand capture, load/iterate
// strobes, result capture and completion reporting.
module division_sequencer
  import Global::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero,
  output logic          dp_load_n,
  output logic          dp_ready,
  output logic [DW-1:0] dp_dividend,
  output logic [DW-1:0] dp_divisor,
  input  logic [DW-1:0] dp_quotient,
  input  logic [DW-1:0] dp_remainder
);

  div_seq_state_e state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [DW-1:0]  quot_q, quot_d;
  logic [DW-1:0]  rem_q, rem_d;
  logic           dbz_q, dbz_d;
  logic           load_n_q, load_n_d;
  logic           ready_q, ready_d;
  logic [DW-1:0]  dvd_q, dvd_d;
  logic [DW-1:0]  dvs_q, dvs_d;
  logic           cnt_last;

  div_iter_counter #(.N(DW)) u_iter_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == LOAD),
    .en    (state_q == ITER),
    .last  (cnt_last)
  );

  // Next state and next registered outputs; outputs are set on entry to the
  // state they belong to, so they are valid throughout that state's cycle.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    load_n_d = 1'b1;
    ready_d  = 1'b1;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = ZERO;
          end else begin
            state_d  = LOAD;
            load_n_d = 1'b0;
          end
        end
      end
      LOAD: begin
        state_d = ITER;
        ready_d = 1'b0;
      end
      ITER: begin
        if (cnt_last) begin
          quot_d  = dp_quotient;
          rem_d   = dp_remainder;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          ready_d = 1'b0;
        end
      end
      ZERO: begin
        quot_d  = '1;
        rem_d   = dvd_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    // Abort overrides every decision above, including result capture.
    if (abort) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      quot_d   = quot_q;
      rem_d    = rem_q;
      dbz_d    = dbz_q;
      load_n_d = 1'b1;
      ready_d  = 1'b1;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
    end
  end

  // State, operand and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      load_n_q <= 1'b1;
      ready_q  <= 1'b1;
      dvd_q    <= '0;
      dvs_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      load_n_q <= load_n_d;
      ready_q  <= ready_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign dp_load_n   = load_n_q;
  assign dp_ready    = ready_q;
  assign dp_dividend = dvd_q;
  assign dp_divisor  = dvs_q;

endmodule
